block_to_frame_scan: RTL and testbench
======================================

# block_to_frame_scan

Inverse of the frame-to-block mapping: accepts a block index on a 640x480 frame tiled into 32x32 blocks (20 columns x 15 rows, indices 0..299) and walks every pixel of that block in raster order, emitting frame `(x, y)` plus in-block offset, one pixel per valid/ready handshake. It sits between block-level logic (block selection, sprite/target placement) and anything addressing pixel memory by frame coordinate. The block index is split into row and column by iterative subtraction, and the scan is fully back-pressurable.

## Interface
Parameters:
- `BLOCKS_X`, 20: blocks per row.
- `BLOCKS_Y`, 15: blocks per column; valid indices are `0..BLOCKS_X*BLOCKS_Y-1`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `start`  in  1  request a scan; sampled only in IDLE.
- `block_coord`  in  9  block index, sampled with `start`.
- `out_ready`  in  1  consumer accepts current pixel.
- `out_valid`  out  1  `frame_x`/`frame_y`/`inblock_coord` hold a pixel.
- `frame_x`  out  10  frame column, `col*32 + ix`.
- `frame_y`  out  10  frame row, `row*32 + iy`.
- `inblock_coord`  out  10  `ix + 32*iy`.
- `busy`  out  1  high in DIV and SCAN.
- `done`  out  1  one-cycle pulse after the last pixel handshake.
- `err`  out  1  one-cycle pulse when `block_coord >= BLOCKS_X*BLOCKS_Y` at start.

## Operation
- States: IDLE, DIV, SCAN.
- IDLE: `start=1` with an out-of-range index pulses `err` for one cycle and stays in IDLE. With an in-range index it loads `rem=block_coord`, `row=0` and enters DIV.
- DIV: each cycle, if `rem >= BLOCKS_X`, then `rem -= BLOCKS_X` and `row += 1`. Otherwise enter SCAN with `frame_x = rem<<5`, `frame_y = row<<5`, `inblock_coord = 0`, `out_valid = 1`.
- SCAN: outputs hold while `out_valid && !out_ready`. On a handshake, `ix` increments. When `ix` wraps from 31 to 0, `iy` increments. `frame_x`, `frame_y` and `inblock_coord` update in the same edge.
- Handshake on `inblock_coord == 1023`: `out_valid` drops, `done` pulses, return to IDLE.
- `start` is ignored while `busy`. `block_coord` changes after sampling have no effect.
- Arithmetic is unsigned. `frame_x` is at most 639 and `frame_y` at most 479, so no overflow in 10 bits.

## Timing
- Reset value: all outputs 0, state IDLE. Reset asserted mid-DIV or mid-SCAN aborts the scan with no `done` and no `err`.
- Start at edge 0: DIV is entered at edge 1 and the row counter resolves at edges 2..row+1. `out_valid` rises at edge `row+2`, where `row = block_coord / BLOCKS_X`.
- SCAN throughput: 1 pixel per cycle with `out_ready` held high. The full block takes 1024 cycles.
- `done` and the `busy` fall occur on the edge after the final handshake. A new `start` is accepted on the next edge, when the block is back in IDLE.
- `err` is asserted on edge 1 after `start`. `busy` never rises for an out-of-range request.

## Configuration
- `BLOCK_SCAN_DIRECT_DIV_EN` defined: DIV is bypassed. Row and column are computed combinationally as `block_coord / BLOCKS_X` and `block_coord % BLOCKS_X`, SCAN is entered at edge 1, and `out_valid` rises after edge 1 for every index.
- Macro undefined: iterative DIV as above, with variable latency `row+2`.
- Output sequences are identical in both builds; only the latency differs.

## Test plan
- `block_coord=0`, `out_ready=1` -> first pixel (0,0), ib 0 at edge 2. Last pixel is (31,31), ib 1023. `done` pulses at edge 1026.
- `block_coord=21` -> first pixel (32,32) at edge 3; pixel 33 is (33,33), ib 33.
- `block_coord=299` -> first pixel (608,448) at edge 16; last pixel (639,479).
- Backpressure: `out_ready` low for 5 cycles mid-scan -> outputs stable, no pixel skipped or repeated. The count of handshakes equals 1024.
- `start` pulsed mid-scan with `block_coord=5` -> ignored. `block_coord=300` from IDLE -> `err` for one cycle, `busy` stays 0, `out_valid` stays 0.
- `reset` asserted at pixel 500 -> all outputs 0 immediately. A subsequent start of block 1 gives first pixel (32,0).

Source files
------------

// File: rtl/block_to_frame_scan.sv
// Walks every pixel of one 32x32 block in raster order as frame (x,y) + in-block offset; first pixel row+2 cycles after start (1 with BLOCK_SCAN_DIRECT_DIV_EN).
// One pixel per valid/ready handshake at full rate; outputs hold while out_ready is low; start is ignored while busy.
module block_to_frame_scan #(
    parameter int BLOCKS_X = 20,
    parameter int BLOCKS_Y = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] block_coord,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [9:0] frame_x,
    output logic [9:0] frame_y,
    output logic [9:0] inblock_coord,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [9:0] NUM_BLOCKS = 10'(BLOCKS_X * BLOCKS_Y);
    localparam logic [8:0] BX         = 9'(BLOCKS_X);

    typedef enum logic [1:0] {IDLE, DIV, SCAN} state_t;

    state_t     state_q;
    logic       out_valid_q, busy_q, done_q, err_q;
    logic [9:0] frame_x_q, frame_y_q, ib_q;
    logic [9:0] col_base_q, row_base_q;
    logic [9:0] ib_d, first_x_d, first_y_d;
    logic       in_range;

    assign in_range = {1'b0, block_coord} < NUM_BLOCKS;
    assign ib_d     = ib_q + 10'd1;

`ifdef BLOCK_SCAN_DIRECT_DIV_EN
    logic [8:0] quo, rmd;
    assign quo       = block_coord / BX;
    assign rmd       = block_coord % BX;
    assign first_x_d = {1'b0, rmd} << 5;
    assign first_y_d = {1'b0, quo} << 5;
`else
    // rem_q ends as the block column once it drops below BLOCKS_X
    logic [8:0] rem_q, row_q;
    assign first_x_d = {1'b0, rem_q} << 5;
    assign first_y_d = {1'b0, row_q} << 5;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_x_q   <= '0;
            frame_y_q   <= '0;
            ib_q        <= '0;
            col_base_q  <= '0;
            row_base_q  <= '0;
`ifndef BLOCK_SCAN_DIRECT_DIV_EN
            rem_q       <= '0;
            row_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (!in_range) begin
                            err_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
`ifdef BLOCK_SCAN_DIRECT_DIV_EN
                            state_q     <= SCAN;
                            out_valid_q <= 1'b1;
                            col_base_q  <= first_x_d;
                            row_base_q  <= first_y_d;
                            frame_x_q   <= first_x_d;
                            frame_y_q   <= first_y_d;
                            ib_q        <= '0;
`else
                            state_q <= DIV;
                            rem_q   <= block_coord;
                            row_q   <= '0;
`endif
                        end
                    end
                end
                DIV: begin
`ifndef BLOCK_SCAN_DIRECT_DIV_EN
                    if (rem_q >= BX) begin
                        rem_q <= rem_q - BX;
                        row_q <= row_q + 9'd1;
                    end else begin
                        state_q     <= SCAN;
                        out_valid_q <= 1'b1;
                        col_base_q  <= first_x_d;
                        row_base_q  <= first_y_d;
                        frame_x_q   <= first_x_d;
                        frame_y_q   <= first_y_d;
                        ib_q        <= '0;
                    end
`else
                    state_q <= IDLE;
`endif
                end
                SCAN: begin
                    if (out_ready) begin
                        if (ib_q == 10'd1023) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            ib_q      <= ib_d;
                            frame_x_q <= col_base_q + {5'b0, ib_d[4:0]};
                            frame_y_q <= row_base_q + {5'b0, ib_d[9:5]};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign frame_x       = frame_x_q;
    assign frame_y       = frame_y_q;
    assign inblock_coord = ib_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_block_to_frame_scan.sv
// Bench for block_to_frame_scan: vector table of block scans plus error, backpressure and reset-abort sequences.
module tb_block_to_frame_scan;
    logic       clk = 1'b0;
    logic       reset, start, out_ready;
    logic [8:0] block_coord;
    logic       out_valid, busy, done, err;
    logic [9:0] frame_x, frame_y, inblock_coord;

    block_to_frame_scan #(.BLOCKS_X(20), .BLOCKS_Y(15)) dut (
        .clk(clk), .reset(reset), .start(start), .block_coord(block_coord),
        .out_ready(out_ready), .out_valid(out_valid), .frame_x(frame_x),
        .frame_y(frame_y), .inblock_coord(inblock_coord), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

`ifdef BLOCK_SCAN_DIRECT_DIV_EN
    localparam bit DIRECT = 1'b1;
`else
    localparam bit DIRECT = 1'b0;
`endif

    typedef struct {int x; int y; int ib;} pix_t;
    typedef struct {
        int coord; int row; int fx; int fy; int lx; int ly; int bp_at; int abort_at;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    pix_t sb_q[$];
    pix_t mon_e;
    int   hs_count = 0;
    int   last_x = -1;
    int   last_y = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted pixel must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            hs_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got (%0d,%0d) ib %0d expected none", frame_x, frame_y, inblock_coord);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pix_x", int'(frame_x), mon_e.x);
                chk("pix_y", int'(frame_y), mon_e.y);
                chk("pix_ib", int'(inblock_coord), mon_e.ib);
                last_x = int'(frame_x);
                last_y = int'(frame_y);
            end
        end
    end

    task automatic push_block(input int c);
        int col, row;
        col = c % 20;
        row = c / 20;
        sb_q.delete();
        for (int iy = 0; iy < 32; iy++)
            for (int ix = 0; ix < 32; ix++)
                sb_q.push_back('{x: col * 32 + ix, y: row * 32 + iy, ib: iy * 32 + ix});
    endtask

    task automatic run_vec(input vec_t v);
        int edges, lat, stall;
        lat   = DIRECT ? 1 : v.row + 2;
        stall = (v.bp_at >= 0) ? 5 : 0;
        push_block(v.coord);
        hs_count = 0;
        @(posedge clk); #1;
        start = 1'b1; block_coord = 9'(v.coord); out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; block_coord = 9'h1AA;
        edges = 1;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1; edges++;
        end
        chk("first_latency", edges, lat);
        chk("first_x", int'(frame_x), v.fx);
        chk("first_y", int'(frame_y), v.fy);
        chk("first_ib", int'(inblock_coord), 0);
        chk("busy_in_scan", int'(busy), 1);
        while (!done && edges < 3000) begin
            if (v.abort_at >= 0 && hs_count == v.abort_at) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_valid", int'(out_valid), 0);
                chk("rst_x", int'(frame_x), 0);
                chk("rst_y", int'(frame_y), 0);
                chk("rst_ib", int'(inblock_coord), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_err", int'(err), 0);
                @(posedge clk); #1;
                reset = 1'b0;
                sb_q.delete();
                return;
            end
            if (v.bp_at >= 0 && hs_count == v.bp_at) begin
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    if (k == 1) begin start = 1'b1; block_coord = 9'd5; end
                    if (k == 2) start = 1'b0;
                    @(posedge clk); #1; edges++;
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_x", int'(frame_x), sb_q[0].x);
                    chk("stall_y", int'(frame_y), sb_q[0].y);
                    chk("stall_ib", int'(inblock_coord), sb_q[0].ib);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1; edges++;
        end
        chk("done_seen", int'(done), 1);
        chk("done_edge", edges, lat + 1024 + stall);
        chk("end_busy", int'(busy), 0);
        chk("end_valid", int'(out_valid), 0);
        chk("handshakes", hs_count, 1024);
        chk("sb_left", sb_q.size(), 0);
        chk("last_x", last_x, v.lx);
        chk("last_y", last_y, v.ly);
        @(posedge clk); #1;
        chk("done_pulse_len", int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(out_valid), 0);
    endtask

    task automatic err_seq(input int c);
        @(posedge clk); #1;
        start = 1'b1; block_coord = 9'(c);
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_set", int'(err), 1);
        chk("err_busy", int'(busy), 0);
        chk("err_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("err_pulse_len", int'(err), 0);
        chk("err_busy_after", int'(busy), 0);
        chk("err_valid_after", int'(out_valid), 0);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{coord:   0, row:  0, fx:   0, fy:   0, lx:  31, ly:  31, bp_at:  -1, abort_at:  -1};
        vecs[1] = '{coord:  21, row:  1, fx:  32, fy:  32, lx:  63, ly:  63, bp_at:  -1, abort_at:  -1};
        vecs[2] = '{coord: 299, row: 14, fx: 608, fy: 448, lx: 639, ly: 479, bp_at:  -1, abort_at:  -1};
        vecs[3] = '{coord:  45, row:  2, fx: 160, fy:  64, lx: 191, ly:  95, bp_at: 100, abort_at:  -1};
        vecs[4] = '{coord:   0, row:  0, fx:   0, fy:   0, lx:  31, ly:  31, bp_at:  -1, abort_at: 500};
        vecs[5] = '{coord:   1, row:  0, fx:  32, fy:   0, lx:  63, ly:  31, bp_at:  -1, abort_at:  -1};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0; block_coord = '0;
        #12;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_x", int'(frame_x), 0);
        chk("reset_ib", int'(inblock_coord), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        err_seq(300);
        err_seq(511);
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
